// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and data access.
// Data requests win by default; fetch is forced through after MAX_STREAK back-to-back
// data grants so it cannot starve. Each access runs IDLE -> ISSUE -> (WAIT) -> ACK.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT - 1);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // owner: 1 = data requester holds the current access, 0 = fetch
    logic              owner;
    logic              owner_nxt;
    logic              we_lat;
    logic              we_nxt;
    logic [3:0]        streak;
    logic [3:0]        streak_nxt;
    logic [2:0]        cnt;
    logic [2:0]        cnt_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic [DATA_W-1:0] if_rdata_nxt;
    logic [DATA_W-1:0] dm_rdata_nxt;
    logic              grant_if;
    logic              capture;

    // Next-state, arbitration, latency sequencing and read-data capture
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        we_nxt       = we_lat;
        streak_nxt   = streak;
        cnt_nxt      = cnt;
        addr_nxt     = mem_addr;
        wdata_nxt    = mem_wdata;
        if_rdata_nxt = if_rdata;
        dm_rdata_nxt = dm_rdata;
        grant_if     = 1'b0;
        capture      = 1'b0;

        case (state)
            IDLE: begin
                if (if_req || dm_req) begin
                    grant_if  = if_req && (!dm_req || (streak == STREAK_MAX));
                    state_nxt = ISSUE;
                    if (grant_if) begin
                        owner_nxt  = 1'b0;
                        we_nxt     = 1'b0;
                        addr_nxt   = if_addr;
                        streak_nxt = 4'd0;
                    end else begin
                        owner_nxt = 1'b1;
                        we_nxt    = dm_we;
                        addr_nxt  = dm_addr;
                        wdata_nxt = dm_wdata;
                        if (!if_req) begin
                            streak_nxt = 4'd0;
                        end else if (streak < STREAK_MAX) begin
                            streak_nxt = streak + 4'd1;
                        end
                    end
                end
            end
            ISSUE: begin
                cnt_nxt = LAT_LOAD;
                if (MEM_LAT == 1) begin
                    capture   = 1'b1;
                    state_nxt = ACK;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 3'd1;
                if (cnt <= 3'd1) begin
                    capture   = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (capture) begin
            if (owner) begin
                dm_rdata_nxt = mem_rdata;
            end else begin
                if_rdata_nxt = mem_rdata;
            end
        end
    end

    // Strobes and acknowledges are decoded from the state so they clear with it
    always_comb begin
        mem_en = (state == ISSUE);
        mem_we = (state == ISSUE) && we_lat;
        if_ack = (state == ACK) && !owner;
        dm_ack = (state == ACK) && owner;
        busy   = (state != IDLE);
    end

    // State and datapath registers; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            we_lat    <= 1'b0;
            streak    <= 4'd0;
            cnt       <= 3'd0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            we_lat    <= we_nxt;
            streak    <= streak_nxt;
            cnt       <= cnt_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            if_rdata  <= if_rdata_nxt;
            dm_rdata  <= dm_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: instance A (MEM_LAT=3) runs directed and random traffic against a
// transaction-level model; instance B (MEM_LAT=1) gets short directed sequences.
module tb_mem_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LAT_A = 3;
    localparam int MAX_A = 4;
    localparam int LAT_B = 1;

    logic clk = 1'b0;
    logic rst;

    logic          if_req_a, if_ack_a, dm_req_a, dm_we_a, dm_ack_a, mem_en_a, mem_we_a, busy_a;
    logic [AW-1:0] if_addr_a, dm_addr_a, mem_addr_a;
    logic [DW-1:0] if_rdata_a, dm_wdata_a, dm_rdata_a, mem_wdata_a, mem_rdata_a;

    logic          if_req_b, if_ack_b, dm_req_b, dm_we_b, dm_ack_b, mem_en_b, mem_we_b, busy_b;
    logic [AW-1:0] if_addr_b, dm_addr_b, mem_addr_b;
    logic [DW-1:0] if_rdata_b, dm_wdata_b, dm_rdata_b, mem_wdata_b, mem_rdata_b;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc;

    // memory behind instance A and the model's own view of what it should hold
    logic [DW-1:0] ram    [64];
    logic [DW-1:0] shadow [64];
    int            age_a;

    // model of instance A: one transaction at a time, described by its grant cycle
    bit            m_inflight;
    int            m_t0;
    bit            m_owner_dm;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_data, m_if_rdata, m_dm_rdata;
    bit            m_dm_known;
    int            m_streak;
    bit            exp_if_ack, exp_dm_ack;

    // snapshots taken at the falling edge
    int            s_cyc;
    logic          s_a_busy, s_a_mem_en, s_a_if_ack, s_a_dm_ack;
    logic [AW-1:0] s_a_mem_addr;
    logic [DW-1:0] s_a_if_rdata, s_a_dm_rdata;
    logic          s_b_busy, s_b_mem_en, s_b_mem_we, s_b_if_ack, s_b_dm_ack;
    logic [AW-1:0] s_b_mem_addr;
    logic [DW-1:0] s_b_mem_wdata, s_b_if_rdata, s_b_dm_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT_A), .MAX_STREAK(MAX_A)) dut_a (
        .clk(clk), .rst(rst),
        .if_req(if_req_a), .if_addr(if_addr_a), .if_ack(if_ack_a), .if_rdata(if_rdata_a),
        .dm_req(dm_req_a), .dm_we(dm_we_a), .dm_addr(dm_addr_a), .dm_wdata(dm_wdata_a),
        .dm_ack(dm_ack_a), .dm_rdata(dm_rdata_a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_rdata(mem_rdata_a), .busy(busy_a)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT_B), .MAX_STREAK(MAX_A)) dut_b (
        .clk(clk), .rst(rst),
        .if_req(if_req_b), .if_addr(if_addr_b), .if_ack(if_ack_b), .if_rdata(if_rdata_b),
        .dm_req(dm_req_b), .dm_we(dm_we_b), .dm_addr(dm_addr_b), .dm_wdata(dm_wdata_b),
        .dm_ack(dm_ack_b), .dm_rdata(dm_rdata_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata_b), .busy(busy_b)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // memories: A returns valid data only in the MEM_LAT-th cycle counted from the strobe,
    // B (latency 1) only while its strobe is high
    task automatic memoryModel();
        if (mem_en_a) begin
            if (mem_we_a) ram[mem_addr_a[7:2]] = mem_wdata_a;
            age_a = 1;
        end else if (age_a != 0) begin
            age_a++;
        end
        if (age_a > LAT_A) age_a = 0;
        mem_rdata_a = (age_a == LAT_A) ? ram[mem_addr_a[7:2]] : $urandom;
        if (mem_en_b) begin
            mem_rdata_b = (mem_addr_b == 32'h10) ? 32'h02309020 : {16'hD00D, mem_addr_b[15:0]};
        end else begin
            mem_rdata_b = 32'hBAD0BAD0;
        end
    endtask

    // expected outputs follow from how many cycles ago the current access was granted
    task automatic modelCompare();
        int ph;
        bit e_en, e_we, e_iack, e_dack, fetch;
        if (m_inflight && (cyc - m_t0) > LAT_A + 1) m_inflight = 1'b0;
        ph     = cyc - m_t0;
        e_en   = m_inflight && (ph == 1);
        e_we   = e_en && m_we;
        e_iack = m_inflight && (ph == LAT_A + 1) && !m_owner_dm;
        e_dack = m_inflight && (ph == LAT_A + 1) && m_owner_dm;
        if (m_inflight && (ph == LAT_A + 1)) begin
            if (!m_owner_dm) begin
                m_if_rdata = m_data;
            end else if (m_we) begin
                m_dm_known = 1'b0;
            end else begin
                m_dm_rdata = m_data;
                m_dm_known = 1'b1;
            end
        end

        checkOutput("busy", 32'(busy_a), 32'(m_inflight));
        checkOutput("mem_en", 32'(mem_en_a), 32'(e_en));
        checkOutput("mem_we", 32'(mem_we_a), 32'(e_we));
        checkOutput("mem_addr", mem_addr_a, m_addr);
        checkOutput("if_ack", 32'(if_ack_a), 32'(e_iack));
        checkOutput("dm_ack", 32'(dm_ack_a), 32'(e_dack));
        checkOutput("if_rdata", if_rdata_a, m_if_rdata);
        if (e_we) checkOutput("mem_wdata", mem_wdata_a, m_wdata);
        if (m_dm_known) checkOutput("dm_rdata", dm_rdata_a, m_dm_rdata);

        exp_if_ack = e_iack;
        exp_dm_ack = e_dack;

        if (!rst) begin
            m_inflight = 1'b0;
            m_streak   = 0;
            m_addr     = '0;
            m_wdata    = '0;
            m_if_rdata = '0;
            m_dm_rdata = '0;
            m_dm_known = 1'b1;
        end else if (!m_inflight && (if_req_a || dm_req_a)) begin
            fetch      = if_req_a && (!dm_req_a || m_streak >= MAX_A);
            m_inflight = 1'b1;
            m_t0       = cyc;
            m_owner_dm = !fetch;
            if (fetch) begin
                m_we     = 1'b0;
                m_addr   = if_addr_a;
                m_streak = 0;
                m_data   = shadow[if_addr_a[7:2]];
            end else begin
                m_we     = dm_we_a;
                m_addr   = dm_addr_a;
                m_wdata  = dm_wdata_a;
                m_streak = if_req_a ? ((m_streak + 1 > MAX_A) ? MAX_A : m_streak + 1) : 0;
                if (dm_we_a) shadow[dm_addr_a[7:2]] = dm_wdata_a;
                m_data   = shadow[dm_addr_a[7:2]];
            end
        end
    endtask

    // one clock cycle: sample and compare at the falling edge, return just after the rising edge
    task automatic step();
        @(negedge clk);
        memoryModel();
        s_cyc         = cyc;
        s_a_busy      = busy_a;
        s_a_mem_en    = mem_en_a;
        s_a_if_ack    = if_ack_a;
        s_a_dm_ack    = dm_ack_a;
        s_a_mem_addr  = mem_addr_a;
        s_a_if_rdata  = if_rdata_a;
        s_a_dm_rdata  = dm_rdata_a;
        s_b_busy      = busy_b;
        s_b_mem_en    = mem_en_b;
        s_b_mem_we    = mem_we_b;
        s_b_if_ack    = if_ack_b;
        s_b_dm_ack    = dm_ack_b;
        s_b_mem_addr  = mem_addr_b;
        s_b_mem_wdata = mem_wdata_b;
        s_b_if_rdata  = if_rdata_b;
        s_b_dm_rdata  = dm_rdata_b;
        modelCompare();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // requester behaviour for instance A: 0 = drop after ack, 1 = stream loads, 2 = random
    task automatic applyStimulus(input int mode);
        case (mode)
            0: begin
                if (exp_if_ack) if_req_a = 1'b0;
                if (exp_dm_ack) dm_req_a = 1'b0;
            end
            1: begin
                if (exp_if_ack) if_req_a = 1'b0;
                if (exp_dm_ack) begin
                    dm_req_a  = 1'b1;
                    dm_we_a   = 1'b0;
                    dm_addr_a = $urandom & 32'h0000_00FC;
                end
            end
            default: begin
                rst = ($urandom_range(0, 149) != 0);
                if (!if_req_a || exp_if_ack) begin
                    if_req_a  = ($urandom_range(0, 99) < 35);
                    if_addr_a = $urandom & 32'h0000_00FC;
                end
                if (!dm_req_a || exp_dm_ack) begin
                    dm_req_a   = ($urandom_range(0, 99) < 45);
                    dm_we_a    = ($urandom_range(0, 1) == 1);
                    dm_addr_a  = $urandom & 32'h0000_00FC;
                    dm_wdata_a = $urandom;
                end
            end
        endcase
    endtask

    initial begin
        int            t0, dcyc, icyc, acks, dacks;
        logic [7:0]    order;
        logic [DW-1:0] fetched;

        rst        = 1'b0;
        if_req_a   = 1'b0; if_addr_a = '0; dm_req_a = 1'b0; dm_we_a = 1'b0;
        dm_addr_a  = '0;   dm_wdata_a = '0; mem_rdata_a = '0;
        if_req_b   = 1'b0; if_addr_b = '0; dm_req_b = 1'b0; dm_we_b = 1'b0;
        dm_addr_b  = '0;   dm_wdata_b = '0; mem_rdata_b = '0;
        cyc        = 0;
        age_a      = 0;
        m_inflight = 1'b0; m_t0 = 0; m_owner_dm = 1'b0; m_we = 1'b0; m_streak = 0;
        m_addr     = '0; m_wdata = '0; m_data = '0; m_if_rdata = '0; m_dm_rdata = '0;
        m_dm_known = 1'b1;
        exp_if_ack = 1'b0; exp_dm_ack = 1'b0;
        for (int i = 0; i < 64; i++) begin
            ram[i]    = $urandom;
            shadow[i] = ram[i];
        end
        ram[16]    = 32'hCAFEF00D;
        shadow[16] = 32'hCAFEF00D;
        @(posedge clk);
        #1;

        // reset held for two cycles, then released with both requests low
        step();
        step();
        rst = 1'b1;
        step();
        checkOutput("reset_b_busy", 32'(s_b_busy), 32'd0);
        checkOutput("reset_b_mem_en", 32'(s_b_mem_en), 32'd0);
        checkOutput("reset_b_mem_addr", s_b_mem_addr, 32'h0);
        checkOutput("reset_b_if_rdata", s_b_if_rdata, 32'h0);
        checkOutput("reset_b_dm_rdata", s_b_dm_rdata, 32'h0);
        checkOutput("reset_a_busy", 32'(s_a_busy), 32'd0);

        // single fetch on the latency-1 instance
        if_req_b  = 1'b1;
        if_addr_b = 32'h10;
        step();
        checkOutput("b_fetch_idle_cycle", 32'(s_b_mem_en), 32'd0);
        step();
        checkOutput("b_fetch_mem_en", 32'(s_b_mem_en), 32'd1);
        checkOutput("b_fetch_mem_addr", s_b_mem_addr, 32'h10);
        checkOutput("b_fetch_mem_we", 32'(s_b_mem_we), 32'd0);
        step();
        checkOutput("b_fetch_if_ack", 32'(s_b_if_ack), 32'd1);
        checkOutput("b_fetch_if_rdata", s_b_if_rdata, 32'h02309020);
        checkOutput("b_fetch_dm_ack", 32'(s_b_dm_ack), 32'd0);
        if_req_b = 1'b0;
        step();
        checkOutput("b_fetch_done_busy", 32'(s_b_busy), 32'd0);
        checkOutput("b_fetch_done_ack", 32'(s_b_if_ack), 32'd0);

        // store on the latency-1 instance
        dm_req_b   = 1'b1;
        dm_we_b    = 1'b1;
        dm_addr_b  = 32'h4;
        dm_wdata_b = 32'h00001AB0;
        step();
        step();
        checkOutput("b_store_mem_en", 32'(s_b_mem_en), 32'd1);
        checkOutput("b_store_mem_we", 32'(s_b_mem_we), 32'd1);
        checkOutput("b_store_mem_addr", s_b_mem_addr, 32'h4);
        checkOutput("b_store_mem_wdata", s_b_mem_wdata, 32'h00001AB0);
        step();
        checkOutput("b_store_strobe_once", 32'(s_b_mem_en), 32'd0);
        checkOutput("b_store_we_once", 32'(s_b_mem_we), 32'd0);
        checkOutput("b_store_dm_ack", 32'(s_b_dm_ack), 32'd1);
        checkOutput("b_store_no_if_ack", 32'(s_b_if_ack), 32'd0);
        dm_req_b = 1'b0;
        dm_we_b  = 1'b0;
        step();

        // contention on instance A: data first, fetch granted right after the data ack
        if_req_a  = 1'b1;
        if_addr_a = 32'h20;
        dm_req_a  = 1'b1;
        dm_we_a   = 1'b0;
        dm_addr_a = 32'h30;
        t0   = cyc;
        dcyc = -1;
        icyc = -1;
        for (int k = 0; k < 40 && icyc < 0; k++) begin
            step();
            if (s_a_dm_ack && dcyc < 0) dcyc = s_cyc;
            if (s_a_if_ack && icyc < 0) icyc = s_cyc;
            applyStimulus(0);
        end
        checkOutput("contention_dm_ack_cycle", 32'(dcyc - t0), 32'(LAT_A + 1));
        checkOutput("contention_if_ack_cycle", 32'(icyc - t0), 32'(2 * LAT_A + 3));
        step();

        // starvation bound: four data grants, then fetch, then data again
        if_req_a  = 1'b1;
        if_addr_a = 32'h24;
        dm_req_a  = 1'b1;
        dm_we_a   = 1'b0;
        dm_addr_a = 32'h34;
        acks  = 0;
        order = '0;
        for (int k = 0; k < 100 && acks < 6; k++) begin
            step();
            if (s_a_dm_ack) begin
                order[acks[2:0]] = 1'b1;
                acks++;
            end else if (s_a_if_ack) begin
                order[acks[2:0]] = 1'b0;
                acks++;
            end
            applyStimulus(1);
        end
        if_req_a = 1'b0;
        dm_req_a = 1'b0;
        checkOutput("starvation_ack_count", 32'(acks), 32'd6);
        checkOutput("starvation_ack_order", 32'(order), 32'h0000_002F);
        step();
        step();

        // reset during the first WAIT cycle of a load
        dm_req_a  = 1'b1;
        dm_we_a   = 1'b0;
        dm_addr_a = 32'h38;
        step();
        step();
        rst = 1'b0;
        step();
        checkOutput("rst_mid_busy_before", 32'(s_a_busy), 32'd1);
        rst      = 1'b1;
        dm_req_a = 1'b0;
        step();
        checkOutput("rst_mid_busy_after", 32'(s_a_busy), 32'd0);
        checkOutput("rst_mid_mem_addr", s_a_mem_addr, 32'h0);
        checkOutput("rst_mid_dm_rdata", s_a_dm_rdata, 32'h0);
        dacks = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (s_a_dm_ack) dacks++;
        end
        checkOutput("rst_mid_no_dm_ack", 32'(dacks), 32'd0);

        // a fresh fetch after the reset completes in MEM_LAT+1 cycles
        if_req_a  = 1'b1;
        if_addr_a = 32'h40;
        t0      = cyc;
        icyc    = -1;
        fetched = '0;
        for (int k = 0; k < 20 && icyc < 0; k++) begin
            step();
            if (s_a_if_ack) begin
                icyc    = s_cyc;
                fetched = s_a_if_rdata;
            end
            applyStimulus(0);
        end
        checkOutput("post_rst_fetch_latency", 32'(icyc - t0), 32'(LAT_A + 1));
        checkOutput("post_rst_fetch_data", fetched, 32'hCAFEF00D);
        step();

        // randomized traffic with occasional resets
        for (int k = 0; k < 3000; k++) begin
            applyStimulus(2);
            step();
        end
        rst      = 1'b1;
        if_req_a = 1'b0;
        dm_req_a = 1'b0;
        for (int k = 0; k < 8; k++) step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
